// File: rtl/farrow_pkg.sv
// Shared widths, Lagrange constants and FSM states for the Farrow
// interpolator/decimator pair.
package farrow_pkg;
   localparam int XW  = 8;
   localparam int YW  = 9;
   localparam int MUW = 8;
   localparam int K85 = 85;
   localparam int K43 = 43;

   typedef enum logic [2:0] {FILL, WAIT_IN, COEF, H1, H2, H3} state_e;

   typedef struct packed {
      logic signed [YW-1:0] c3;
      logic signed [YW-1:0] c2;
      logic signed [YW-1:0] c1;
      logic signed [YW-1:0] c0;
   } coef_t;
endpackage

// File: rtl/farrow_interp_if.sv
// Sample-in / sample-out handshake bundle of the Farrow interpolator.
interface farrow_interp_if;
   import farrow_pkg::*;
   logic signed [XW-1:0] x_in;
   logic                 x_valid;
   logic                 x_ready;
   logic signed [YW-1:0] y_out;
   logic                 y_valid;

   modport master (output x_in, x_valid, input x_ready, y_out, y_valid);
   modport slave  (input x_in, x_valid, output x_ready, y_out, y_valid);
endinterface

// File: rtl/farrow_horner_step.sv
// One Horner step y = ((a*mu) >>> 8) + b, 9-bit wrap; the only multiplier.
module farrow_horner_step
   import farrow_pkg::*;
(
   input  logic signed [YW-1:0] a_i,
   input  logic [MUW-1:0]       mu_i,
   input  logic signed [YW-1:0] b_i,
   output logic signed [YW-1:0] y_o
);
   logic signed [2*YW-1:0] prod;
   logic                   unused_bits;

   // mu is an unsigned fraction, so zero-extend before the signed multiply
   assign prod        = a_i * $signed({1'b0, mu_i});
   assign y_o         = $signed(prod[YW+7:8]) + b_i;
   assign unused_bits = ^{prod[2*YW-1], prod[7:0]};
endmodule

// File: rtl/farrow_interp.sv
// Cubic Lagrange Farrow interpolator: 4-tap buffer, coefficient stage and a
// time-shared Horner evaluation producing 256/DELTA outputs per input.
module farrow_interp
   import farrow_pkg::*;
#(
   parameter int unsigned DELTA = 192,
   parameter int unsigned IL    = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   farrow_interp_if.slave       bus,
   output logic [MUW-1:0]       mu_o,
   output logic signed [YW-1:0] c0_o,
   output logic signed [YW-1:0] c1_o,
   output logic signed [YW-1:0] c2_o,
   output logic signed [YW-1:0] c3_o
);
   localparam int WW = 16;
   localparam int CW = $clog2(IL + 1);
   localparam logic signed [WW-1:0] K85W  = WW'(K85);
   localparam logic signed [WW-1:0] K43W  = WW'(K43);
   localparam logic [MUW:0]         DSTEP = (MUW+1)'(DELTA);

   state_e               state_q, state_d;
   logic [IL:0][XW-1:0]  x_q;
   logic [CW-1:0]        cnt_q;
   coef_t                coef_q, coef_d;
   logic [MUW-1:0]       mu_q;
   logic signed [YW-1:0] acc_q, y_q;
   logic                 yv_q;
   logic                 rdy, xfer;
   logic [MUW:0]         step_s;
   logic signed [YW-1:0] h_a, h_b, h_y;
   logic signed [WW-1:0] x0, x1, x2, x3, t85, t43, hx1, c1w, c2w, c3w;
   logic                 unused_hi;

   assign rdy    = (state_q == FILL) || (state_q == WAIT_IN);
   assign xfer   = rdy & bus.x_valid;
   assign step_s = {1'b0, mu_q} + DSTEP;

   // Coefficients evaluated wide and exact, then wrapped to 9 bits
   always_comb begin
      x0  = WW'($signed(x_q[0]));
      x1  = WW'($signed(x_q[1]));
      x2  = WW'($signed(x_q[2]));
      x3  = WW'($signed(x_q[3]));
      t85 = (-(K85W * x0)) >>> 8;
      t43 = (K43W * x3) >>> 8;
      // bias negatives by one so the shift truncates toward zero
      hx1 = (x1 + $signed(WW'(x1[WW-1]))) >>> 1;
      c1w = t85 - hx1 + x2 - t43;
      c2w = ((x0 + x2) >>> 1) - x1;
      c3w = ((x1 - x2) >>> 1) + ((K43W * (x3 - x0)) >>> 8);
      coef_d.c0 = x1[YW-1:0];
      coef_d.c1 = c1w[YW-1:0];
      coef_d.c2 = c2w[YW-1:0];
      coef_d.c3 = c3w[YW-1:0];
   end
   assign unused_hi = ^{c1w[WW-1:YW], c2w[WW-1:YW], c3w[WW-1:YW]};

   farrow_horner_step u_step (
      .a_i  (h_a),
      .mu_i (mu_q),
      .b_i  (h_b),
      .y_o  (h_y)
   );

   always_comb begin
      state_d = state_q;
      h_a     = acc_q;
      h_b     = coef_q.c0;
      case (state_q)
         FILL:    if (xfer && cnt_q == CW'(IL)) state_d = COEF;
         WAIT_IN: if (xfer) state_d = COEF;
         COEF:    state_d = H1;
         H1: begin
            state_d = H2;
            h_a     = coef_q.c3;
            h_b     = coef_q.c2;
         end
         H2: begin
            state_d = H3;
            h_b     = coef_q.c1;
         end
         H3:      state_d = step_s[MUW] ? WAIT_IN : H1;
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FILL;
         x_q     <= '0;
         cnt_q   <= '0;
         coef_q  <= '0;
         mu_q    <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         yv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         yv_q    <= (state_q == H3);
         if (xfer) begin
            x_q <= {bus.x_in, x_q[IL:1]};
            if (state_q == FILL) cnt_q <= cnt_q + CW'(1);
         end
         case (state_q)
            COEF:   coef_q <= coef_d;
            H1, H2: acc_q  <= h_y;
            H3: begin
               y_q  <= h_y;
               mu_q <= step_s[MUW-1:0];
            end
            default: ;
         endcase
      end
   end

   assign bus.x_ready = rdy;
   assign bus.y_out   = y_q;
   assign bus.y_valid = yv_q;
   assign mu_o        = mu_q;
   assign c0_o        = coef_q.c0;
   assign c1_o        = coef_q.c1;
   assign c2_o        = coef_q.c2;
   assign c3_o        = coef_q.c3;
endmodule

// File: tb/tb_farrow_interp.sv
// Bench for farrow_interp: two instances (DELTA 192 and 85) share stimulus and
// are checked against a sample-window model of the cubic Lagrange interpolator.
module tb_farrow_interp;
   import farrow_pkg::*;
   localparam int DA = 192;
   localparam int DB = 85;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   farrow_interp_if bus_a ();
   farrow_interp_if bus_b ();
   logic [MUW-1:0]       mu_a, mu_b;
   logic signed [YW-1:0] ca [4];
   logic signed [YW-1:0] cb [4];

   farrow_interp #(.DELTA(DA), .IL(3)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .mu_o(mu_a),
      .c0_o(ca[0]), .c1_o(ca[1]), .c2_o(ca[2]), .c3_o(ca[3]));
   farrow_interp #(.DELTA(DB), .IL(3)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .mu_o(mu_b),
      .c0_o(cb[0]), .c1_o(cb[1]), .c2_o(cb[2]), .c3_o(cb[3]));

   int tests = 0;
   int fails = 0;
   // model state per instance (0 = A, 1 = B)
   int samp [2][2048];
   int nsamp [2], w [2], m [2], pm [2], mc [2][4];
   int dl [2] = '{DA, DB};
   int nx [2], gap [2], have_prev [2], prev_carry [2];
   int xcount [2], scount [2], last_y [2], last_mu [2];
   bit st [2];

   function automatic int wrap9(input int v);
      return ((v + 256) & 511) - 256;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         nsamp[d] = 0; w[d] = 0; m[d] = 0; pm[d] = 0; nx[d] = 0; gap[d] = 0;
         have_prev[d] = 0; prev_carry[d] = 0; xcount[d] = 0; scount[d] = 0;
      end
   endtask

   task automatic model_step(input int d, output int y, output int used);
      int x0, x1, x2, x3, c0, c1, c2, c3, a, s;
      x0 = samp[d][w[d]];   x1 = samp[d][w[d]+1];
      x2 = samp[d][w[d]+2]; x3 = samp[d][w[d]+3];
      c0 = x1;
      c1 = wrap9(((-85 * x0) >>> 8) - x1 / 2 + x2 - ((43 * x3) >>> 8));
      c2 = wrap9(((x0 + x2) >>> 1) - x1);
      c3 = wrap9(((x1 - x2) >>> 1) + ((43 * (x3 - x0)) >>> 8));
      mc[d][0] = c0; mc[d][1] = c1; mc[d][2] = c2; mc[d][3] = c3;
      used = m[d];
      a = wrap9(c2 + ((c3 * used) >>> 8));
      a = wrap9(((a * used) >>> 8) + c1);
      y = wrap9(((a * used) >>> 8) + c0);
      s = used + dl[d];
      prev_carry[d] = (s >= 256) ? 1 : 0;
      m[d] = s % 256;
      if (s >= 256) w[d]++;
   endtask

   task automatic observe(input int d, input logic xfer, input logic [7:0] din,
                          input logic yv, input logic signed [YW-1:0] yo, input logic [7:0] mu);
      int ey, em;
      string pfx;
      pfx = (d == 0) ? "A" : "B";
      st[d] = 1'b0;
      gap[d]++;
      if (xfer) begin
         if (nsamp[d] < 2048) samp[d][nsamp[d]] = int'($signed(din));
         nsamp[d]++; xcount[d]++; nx[d]++;
      end
      if (yv !== 1'b0) begin
         st[d] = 1'b1;
         scount[d]++;
         last_mu[d] = pm[d];
         last_y[d]  = int'(yo);
         chk({pfx, "_known"}, $isunknown({yv, yo}), 0);
         if (have_prev[d] != 0) begin
            chk({pfx, "_xfers_between"}, nx[d], prev_carry[d]);
            chk({pfx, "_gap"}, (gap[d] >= ((nx[d] > 0) ? 5 : 3)) ? 1 : 0, 1);
         end
         chk({pfx, "_window_ready"}, (nsamp[d] >= w[d] + 4) ? 1 : 0, 1);
         if (nsamp[d] >= w[d] + 4) begin
            model_step(d, ey, em);
            chk({pfx, "_mu_used"}, pm[d], em);
            chk({pfx, "_y"}, yo, ey);
         end
         have_prev[d] = 1; nx[d] = 0; gap[d] = 0;
      end
      pm[d] = int'(mu);
   endtask

   task automatic cyc(input logic v, input logic [7:0] da, input logic [7:0] db);
      logic ra, rb;
      bus_a.x_valid = v; bus_a.x_in = da;
      bus_b.x_valid = v; bus_b.x_in = db;
      ra = bus_a.x_ready; rb = bus_b.x_ready;
      @(posedge clk); #1;
      observe(0, v & ra, da, bus_a.y_valid, bus_a.y_out, mu_a);
      observe(1, v & rb, db, bus_b.y_valid, bus_b.y_out, mu_b);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      bus_a.x_valid = 1'b0; bus_b.x_valid = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int seq [5] = '{0, 192, 128, 64, 0};
      int k, n3, ec, mu, car, s, y2 [2], n2;
      assert (DA > 0 && DA < 256 && DB > 0 && DB < 256)
         else $fatal(1, "FAIL delta_range: DELTA outside 1..255");
      reset = 1'b0;
      bus_a.x_valid = 1'b0; bus_a.x_in = '0;
      bus_b.x_valid = 1'b0; bus_b.x_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_y", bus_a.y_out, 0);
      chk("rst_yv", bus_a.y_valid, 0);
      chk("rst_mu", mu_a, 0);
      for (int i = 0; i < 4; i++) chk("rst_c", ca[i], 0);
      chk("rst_rdy", bus_a.x_ready, 1);
      @(negedge clk);
      reset = 1'b1;

      // constant input: flat output, mu walks 0,192,128,64,0
      k = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 8'd64, 8'd64);
         if (st[0] && k < 5) begin
            chk("t1_mu", last_mu[0], seq[k]);
            chk("t1_y", last_y[0], 64);
            if (k == 0) begin
               chk("t1_c0", ca[0], 64);
               chk("t1_c1", ca[1], 0);
               chk("t1_c2", ca[2], 0);
               chk("t1_c3", ca[3], 0);
            end
            k++;
         end
      end
      chk("t1_n", k, 5);

      // ramp then stall
      do_reset();
      cyc(1'b1, 8'd0, 8'd0);   cyc(1'b1, 8'd16, 8'd16);
      cyc(1'b1, 8'd32, 8'd32); cyc(1'b1, 8'd48, 8'd48);
      n2 = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 8'd0, 8'd0);
         if (st[0]) begin
            if (n2 < 2) y2[n2] = last_y[0];
            n2++;
         end
      end
      chk("t2_n", n2, 2);
      chk("t2_y0", y2[0], 16);
      chk("t2_y1", y2[1], 28);
      chk("t2_mu", mu_a, 128);
      chk("t2_rdy", bus_a.x_ready, 1);
      chk("t2_c0", ca[0], 16);
      chk("t2_c1", ca[1], 16);
      chk("t2_c2", ca[2], 0);
      chk("t2_c3", ca[3], 0);

      // stall in WAIT_IN: everything holds
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 8'd0, 8'd0);
         chk("t4_yv", bus_a.y_valid, 0);
         chk("t4_mu", mu_a, m[0]);
      end
      for (int i = 0; i < 4; i++) chk("t4_c", ca[i], mc[0][i]);
      cyc(1'b1, 8'd80, 8'd80);
      for (int j = 1; j <= 4; j++) begin
         cyc(1'b0, 8'd0, 8'd0);
         chk("t4_latency", bus_a.y_valid, (j == 4) ? 1 : 0);
      end

      // reset while A is in H2
      cyc(1'b1, 8'd96, 8'd96);
      cyc(1'b0, 8'd0, 8'd0);
      cyc(1'b0, 8'd0, 8'd0);
      bus_a.x_valid = 1'b0; bus_b.x_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("t5_y", bus_a.y_out, 0);
      chk("t5_yv", bus_a.y_valid, 0);
      chk("t5_mu", mu_a, 0);
      for (int i = 0; i < 4; i++) chk("t5_c", ca[i], 0);
      chk("t5_rdy", bus_a.x_ready, 1);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20 && xcount[0] < 4; i++) begin
         cyc((i % 2) == 0, 8'(i * 7), 8'(i * 7));
         chk("t5_quiet", bus_a.y_valid, 0);
      end
      chk("t5_fill", xcount[0], 4);
      for (int j = 1; j <= 4; j++) begin
         cyc(1'b0, 8'd0, 8'd0);
         chk("t5_latency", bus_a.y_valid, (j == 4) ? 1 : 0);
      end

      // long continuous run: 300 inputs after fill give 400 outputs
      do_reset();
      n3 = 0;
      for (int i = 0; i < 3000 && xcount[0] < 304; i++) begin
         cyc(xcount[0] < 304, 8'($urandom), 8'($urandom));
         if (st[0] && xcount[0] >= 5) n3++;
      end
      for (int i = 0; i < 30; i++) begin
         cyc(1'b0, 8'd0, 8'd0);
         if (st[0] && xcount[0] >= 5) n3++;
      end
      chk("t3_fed", xcount[0], 304);
      chk("t3_strobes", n3, 400);

      // full-scale alternation on the DELTA=85 instance
      do_reset();
      for (int i = 0; i < 1000 && xcount[1] < 40; i++)
         cyc(1'b1, (xcount[1] % 2 == 0) ? 8'h80 : 8'h7F, (xcount[1] % 2 == 0) ? 8'h80 : 8'h7F);
      for (int i = 0; i < 60; i++) cyc(1'b0, 8'd0, 8'd0);
      ec = 0; mu = 0; car = 0;
      while (car < 37) begin
         ec++;
         s = mu + DB;
         if (s >= 256) car++;
         mu = s % 256;
      end
      chk("t6_fed", xcount[1], 40);
      chk("t6_strobes", scount[1], ec);

      // random data with random gaps on x_valid
      do_reset();
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
      for (int i = 0; i < 20; i++) cyc(1'b0, 8'd0, 8'd0);
      chk("rnd_active", (scount[0] > 10 && scount[1] > 10) ? 1 : 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
